rr_mux2_stream: RTL
===================

Name: rr_mux2_stream

Overview:
- Registered 2-input stream selector feeding the team's 2:1 mux datapath.
- Arbitrates between two valid/ready sources, channel A and channel B, using a round-robin policy.
- Drives the select (sel=0 -> A, sel=1 -> B), moves one beat per cycle into a single output register, and counts granted beats per channel.
- Sits directly upstream of any consumer of the muxed stream.

Parameters:
- DATA_W, 8: width of a_data, b_data and y_data.
- CNT_W, 16: width of the per-channel beat counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- a_data  input  DATA_W  channel A payload.
- a_valid  input  1  channel A beat available.
- a_ready  output  1  channel A beat accepted this cycle.
- b_data  input  DATA_W  channel B payload.
- b_valid  input  1  channel B beat available.
- b_ready  output  1  channel B beat accepted this cycle.
- sel  output  1  combinational grant for this cycle; 0 = A, 1 = B.
- y_data  output  DATA_W  registered output payload.
- y_valid  output  1  output register holds a beat.
- y_ready  input  1  downstream accepts y_data.
- y_src  output  1  source of the beat in y_data; 0 = A, 1 = B.
- cnt_a  output  CNT_W  beats accepted from A.
- cnt_b  output  CNT_W  beats accepted from B.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n, sampled only at a rising clk edge.
- Reset values: y_valid=0, y_data=0, y_src=0, cnt_a=0, cnt_b=0, last_grant=1 (so A wins the first contention).
- Load enable: load_en = !y_valid || y_ready. The output register can accept a new beat in the same cycle it is drained.
- Grant, combinational:
  - Only a_valid -> A.
  - Only b_valid -> B.
  - Both valid -> the channel opposite last_grant.
  - Neither valid -> sel holds last_grant.
- Ready signals:
  - a_ready = load_en && a_valid && sel==0.
  - b_ready = load_en && b_valid && sel==1.
  - Never both high in the same cycle.
  - Ready never depends on ready of the other input.
- Transfer (at an edge where a_ready or b_ready is 1):
  - y_data <= granted data; y_src <= sel; y_valid <= 1.
  - last_grant <= sel.
  - Matching counter increments by 1 and wraps from 2^CNT_W-1 to 0.
- Drain: at an edge with y_valid && y_ready and no new transfer, y_valid <= 0. y_data and y_src hold their last values.
- Stall: y_valid && !y_ready -> y_data, y_src and y_valid are stable; both input readies are 0; last_grant is unchanged.
- Latency: one cycle from input acceptance to y_valid. Full throughput is 1 beat/cycle when y_ready is held at 1.
- Fairness: with both inputs valid continuously and y_ready=1, the accepted sequence is A,B,A,B,...
- The arbitration pointer only advances on an actual transfer; a stall or idle cycle never skips a channel.
- Reset mid-operation: a beat held in the output register is discarded (y_valid=0 at the next edge). Counters and last_grant return to their reset values. Inputs are not accepted during the reset edge.
- Protocol assumption: sources keep valid and data stable until accepted. The block does not check for violations.

Test Plan:
- Reset then idle: rst_n low for 2 cycles, then all valids 0 -> y_valid=0, cnt_a=cnt_b=0, sel=1, no readies asserted.
- Single source: a_valid=1 with a_data=0x11,0x22,0x33, y_ready=1 -> a_ready=1 every cycle; y_data sequence 0x11,0x22,0x33 one cycle later with y_src=0; cnt_a=3, cnt_b=0.
- Contention: a_valid=b_valid=1 for 4 cycles, a_data=0xAA, b_data=0xBB, y_ready=1 -> y_data = AA,BB,AA,BB; y_src = 0,1,0,1; cnt_a=2, cnt_b=2.
- Back-pressure: a beat 0x5A in the output register, y_ready=0 for 3 cycles with both inputs valid -> y_data stays 0x5A, a_ready=b_ready=0; when y_ready rises, the next grant goes to the channel opposite y_src in the same cycle.
- Counter wrap: CNT_W=4, 17 A-only beats -> cnt_a=1.
- Mid-stream reset: rst_n pulsed low for 1 cycle while y_valid=1 and cnt_b=5 -> after the edge y_valid=0, cnt_b=0; the next contention grants A first.

Source files
------------

// File: rtl/rr_mux2_stream.sv
// rr_mux2_stream
//
// Registered two-input stream selector with round-robin arbitration.
// Two valid/ready sources (A and B) compete for a single output register.
// When both request, the one that did not win the previous transfer is
// granted, so continuous contention yields A,B,A,B,...  The output register
// can be refilled in the same cycle it is drained, giving 1 beat/cycle.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    synchronous reset, active-low
//   a_data   channel A payload          (DATA_W)
//   a_valid  channel A beat available
//   a_ready  channel A beat accepted this cycle
//   b_data   channel B payload          (DATA_W)
//   b_valid  channel B beat available
//   b_ready  channel B beat accepted this cycle
//   sel      combinational grant for this cycle, 0 = A, 1 = B
//   y_data   registered output payload  (DATA_W)
//   y_valid  output register holds a beat
//   y_ready  downstream accepts y_data
//   y_src    source of the beat in y_data, 0 = A, 1 = B
//   cnt_a    beats accepted from A      (CNT_W, wraps)
//   cnt_b    beats accepted from B      (CNT_W, wraps)

module rr_mux2_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] a_data,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [DATA_W-1:0] b_data,
    input  logic              b_valid,
    output logic              b_ready,
    output logic              sel,
    output logic [DATA_W-1:0] y_data,
    output logic              y_valid,
    input  logic              y_ready,
    output logic              y_src,
    output logic [CNT_W-1:0]  cnt_a,
    output logic [CNT_W-1:0]  cnt_b
);

    // Channel that won the most recent transfer; the other one wins the
    // next contention. Resets to B so that A wins the first contention.
    logic last_grant;
    logic load_en;
    logic xfer;

    // The output register is free when empty or being drained this cycle.
    assign load_en = !y_valid || y_ready;

    // Grant: a lone requester always wins; under contention the pointer
    // decides; with no requester sel simply shows the pointer so it does
    // not toggle on idle cycles.
    always_comb begin
        sel = last_grant;
        if (a_valid && !b_valid) begin
            sel = 1'b0;
        end else if (!a_valid && b_valid) begin
            sel = 1'b1;
        end else if (a_valid && b_valid) begin
            sel = !last_grant;
        end
    end

    // Readies are gated by rst_n so a source never sees its beat taken on
    // a reset edge, where the register ignores the transfer anyway.
    assign a_ready = rst_n && load_en && a_valid && !sel;
    assign b_ready = rst_n && load_en && b_valid &&  sel;
    assign xfer    = a_ready || b_ready;

    // Output register, arbitration pointer and beat counters. The pointer
    // moves only on an actual transfer so stalls never skip a channel.
    // On a plain drain y_data/y_src keep their last values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid    <= 1'b0;
            y_data     <= '0;
            y_src      <= 1'b0;
            cnt_a      <= '0;
            cnt_b      <= '0;
            last_grant <= 1'b1;
        end else if (xfer) begin
            y_valid    <= 1'b1;
            y_data     <= sel ? b_data : a_data;
            y_src      <= sel;
            last_grant <= sel;
            if (sel) begin
                cnt_b <= cnt_b + 1'b1;
            end else begin
                cnt_a <= cnt_a + 1'b1;
            end
        end else if (y_valid && y_ready) begin
            y_valid <= 1'b0;
        end
    end

endmodule
